// File: rtl/mult_pkg.sv
// Shared definitions for the sequential shift-and-add multiplier:
// FSM state encoding, default operand width and iteration counter sizing.
package mult_pkg;

    localparam int DEFAULT_WIDTH = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Iteration counter must hold 0..WIDTH-1; keep at least one bit.
    function automatic int cnt_width(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

    localparam int DEFAULT_CNT_W = cnt_width(DEFAULT_WIDTH);

endpackage

// File: rtl/add_stage.sv
// Combinational WIDTH-bit adder with carry-in/carry-out, kept as its own
// module so alternative adder architectures can be dropped in.
module add_stage #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};

endmodule

// File: rtl/seq_shift_add_mult.sv
// Sequential radix-2 shift-and-add multiplier, WIDTH x WIDTH -> 2*WIDTH, one
// iteration per clock. Define SIGNED_MULT_EN for two's-complement operands.
module seq_shift_add_mult
    import mult_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start_valid,
    output logic               start_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               result_valid,
    input  logic               result_ready,
    output logic [2*WIDTH-1:0] product
);

    localparam int CW = cnt_width(WIDTH);

    state_t             state;
    state_t             state_next;
    logic [WIDTH-1:0]   mcand;
    logic [WIDTH-1:0]   acc_hi;
    logic [WIDTH-1:0]   acc_lo;
    logic [CW-1:0]      count;
    logic [WIDTH-1:0]   add_b;
    logic [WIDTH-1:0]   sum;
    logic               carry;
    logic [2*WIDTH-1:0] shifted;
    logic [2*WIDTH-1:0] final_product;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic               accept;
    logic               last_iter;

    assign start_ready  = (state == ST_IDLE);
    assign busy         = (state == ST_RUN);
    assign result_valid = (state == ST_DONE);
    assign accept       = start_valid && start_ready;
    assign last_iter    = (count == CW'(WIDTH - 1));

    // Multiplicand is added only when the current multiplier bit is set.
    assign add_b = acc_lo[0] ? mcand : '0;

    add_stage #(.WIDTH(WIDTH)) u_add (
        .a    (acc_hi),
        .b    (add_b),
        .cin  (1'b0),
        .sum  (sum),
        .cout (carry)
    );

    // Carry becomes the new MSB so the 2*WIDTH+1-bit shift never loses it.
    assign shifted = {carry, sum, acc_lo[WIDTH-1:1]};

`ifdef SIGNED_MULT_EN
    logic neg_flag;

    // The most-negative value negates to itself, which is its correct unsigned magnitude.
    assign a_mag         = a[WIDTH-1] ? -a : a;
    assign b_mag         = b[WIDTH-1] ? -b : b;
    assign final_product = neg_flag ? -shifted : shifted;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            neg_flag <= 1'b0;
        end else if (accept) begin
            neg_flag <= a[WIDTH-1] ^ b[WIDTH-1];
        end
    end
`else
    assign a_mag         = a;
    assign b_mag         = b;
    assign final_product = shifted;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (accept)       state_next = ST_RUN;
            ST_RUN:  if (last_iter)    state_next = ST_DONE;
            ST_DONE: if (result_ready) state_next = ST_IDLE;
            default:                   state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand   <= '0;
            acc_hi  <= '0;
            acc_lo  <= '0;
            count   <= '0;
            product <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        mcand  <= a_mag;
                        acc_hi <= '0;
                        acc_lo <= b_mag;
                        count  <= '0;
                    end
                end
                ST_RUN: begin
                    {acc_hi, acc_lo} <= shifted;
                    count            <= count + 1'b1;
                    if (last_iter) begin
                        product <= final_product;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_shift_add_mult.sv
// Self-checking bench for seq_shift_add_mult: directed and random operands
// scored against an arithmetic reference model through an expectation queue.
module tb_seq_shift_add_mult;

    localparam int WIDTH = 32;
    localparam int CYCLE_BOUND = 200;

    logic               clk;
    logic               rst_n;
    logic               start_valid;
    logic               start_ready;
    logic [WIDTH-1:0]   a;
    logic [WIDTH-1:0]   b;
    logic               busy;
    logic               result_valid;
    logic               result_ready;
    logic [2*WIDTH-1:0] product;

    int tests_run;
    int tests_failed;
    logic [2*WIDTH-1:0] exp_q[$];

    seq_shift_add_mult #(.WIDTH(WIDTH)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start_valid  (start_valid),
        .start_ready  (start_ready),
        .a            (a),
        .b            (b),
        .busy         (busy),
        .result_valid (result_valid),
        .result_ready (result_ready),
        .product      (product)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference product from plain integer arithmetic.
    function automatic logic [2*WIDTH-1:0] modelProduct(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
`ifdef SIGNED_MULT_EN
        longint sx;
        longint sy;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        return 64'(sx * sy);
`else
        longint unsigned ux;
        longint unsigned uy;
        ux = 64'(x);
        uy = 64'(y);
        return ux * uy;
`endif
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%016h, expected 0x%016h", name, actual, expected);
        end
    endtask

    // Monitor: every handoff pops the oldest expectation.
    always @(negedge clk) begin
        if (rst_n && result_valid && result_ready) begin
            if (exp_q.size() == 0) begin
                checkOutput("unexpected_result", 64'(result_valid), 64'd0);
            end else begin
                checkOutput("product", product, exp_q.pop_front());
            end
        end
    end

    // One transaction; abort_at >= 0 resets the block after that many RUN cycles.
    task automatic applyStimulus(input logic [WIDTH-1:0] aa, input logic [WIDTH-1:0] bb,
                                 input int hold, input int abort_at);
        int n;
        int busy_n;
        logic [2*WIDTH-1:0] expv;

        n = 0;
        while (!start_ready && n < CYCLE_BOUND) begin
            @(posedge clk); #1;
            n++;
        end
        checkOutput("start_ready_wait", 64'(start_ready), 64'd1);

        a = aa;
        b = bb;
        start_valid = 1'b1;
        @(posedge clk); #1;
        start_valid = 1'b0;
        a = $urandom;
        b = $urandom;
        expv = modelProduct(aa, bb);

        if (abort_at >= 0) begin
            repeat (abort_at) @(posedge clk);
            #3 rst_n = 1'b0;
            #1;
            checkOutput("abort_product", product, 64'd0);
            checkOutput("abort_valid", 64'(result_valid), 64'd0);
            checkOutput("abort_busy", 64'(busy), 64'd0);
            checkOutput("abort_start_ready", 64'(start_ready), 64'd1);
            #2 rst_n = 1'b1;
            return;
        end

        exp_q.push_back(expv);
        n = 0;
        busy_n = 0;
        while (!result_valid && n < CYCLE_BOUND) begin
            if (busy) busy_n++;
            @(posedge clk); #1;
            n++;
        end
        checkOutput("latency", 64'(n), 64'(WIDTH));
        checkOutput("busy_cycles", 64'(busy_n), 64'(WIDTH));

        for (int k = 0; k < hold; k++) begin
            start_valid = 1'($urandom_range(0, 1));
            a = $urandom;
            b = $urandom;
            @(posedge clk); #1;
            checkOutput("hold_valid", 64'(result_valid), 64'd1);
            checkOutput("hold_start_ready", 64'(start_ready), 64'd0);
            checkOutput("hold_product", product, expv);
        end
        start_valid = 1'b0;

        result_ready = 1'b1;
        @(posedge clk); #1;
        result_ready = 1'b0;
        checkOutput("valid_drop", 64'(result_valid), 64'd0);
        checkOutput("idle_after_handoff", 64'(start_ready), 64'd1);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst_n        = 1'b0;
        start_valid  = 1'b0;
        result_ready = 1'b0;
        a            = '0;
        b            = '0;

        repeat (2) @(posedge clk);
        #3;
        checkOutput("reset_product", product, 64'd0);
        checkOutput("reset_valid", 64'(result_valid), 64'd0);
        checkOutput("reset_busy", 64'(busy), 64'd0);
        rst_n = 1'b1;
        #1;
        checkOutput("reset_start_ready", 64'(start_ready), 64'd1);

        applyStimulus(32'd3, 32'd5, 0, -1);
        applyStimulus(32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, -1);
        applyStimulus(32'd7, 32'd9, 5, -1);
        applyStimulus(32'h1234, 32'h10, 0, 10);
        applyStimulus(32'd2, 32'd2, 0, -1);
        applyStimulus(32'hFFFF_FFFD, 32'd5, 1, -1);
        applyStimulus(32'h8000_0000, 32'hFFFF_FFFF, 0, -1);
        applyStimulus(32'h8000_0000, 32'h8000_0000, 0, -1);
        applyStimulus(32'd0, $urandom, 0, -1);
        applyStimulus($urandom, 32'd0, 0, -1);

        for (int i = 0; i < 20; i++) begin
            applyStimulus($urandom, $urandom, $urandom_range(0, 3), -1);
        end

        repeat (3) @(posedge clk);
        #1;
        checkOutput("scoreboard_empty", 64'(exp_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/seq_shift_add_mult.md
Name: seq_shift_add_mult

Overview:
Sequential radix-2 shift-and-add multiplier, WIDTH x WIDTH -> 2*WIDTH.
Sits directly upstream of the 32-bit adder datapath. It sequences multiplicand/partial-sum operand pairs into one adder sub-module, one iteration per clock.
Valid/ready handshake on the operand and result sides lets it drop into the arithmetic test pipeline alongside the combinational adders.

Parameters:
WIDTH, 32, operand width. Product is 2*WIDTH. Iteration count is WIDTH.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
start_valid  input  1  operands a/b presented
start_ready  output  1  block can accept operands (high only in IDLE)
a  input  WIDTH  multiplicand
b  input  WIDTH  multiplier
busy  output  1  high in RUN
result_valid  output  1  product available (high only in DONE)
result_ready  input  1  consumer takes product
product  output  2*WIDTH  registered result

Behaviour:
- Reset (rst_n low, async): state=IDLE, count=0, product=0, result_valid=0, busy=0, start_ready=1 once rst_n is high. All internal registers are cleared.
- States:
  - IDLE: start_ready=1. On start_valid&&start_ready at a clock edge:
    - mcand<=a, acc_hi<=0, acc_lo<=b, count<=0.
    - Go to RUN.
  - RUN: each cycle:
    - If acc_lo[0]=1, {c,sum} = acc_hi + mcand + 0. Otherwise {c,sum} = {0,acc_hi}.
    - {acc_hi,acc_lo} <= {c,sum,acc_lo[WIDTH-1:1]}, i.e. 2*WIDTH+1 bits shifted right 1. The carry is never lost.
    - count increments. When count==WIDTH-1, the last iteration writes product and goes to DONE.
  - DONE: result_valid=1, product stable. On result_valid&&result_ready, go to IDLE and drop result_valid the next cycle.
- Latency:
  - result_valid rises exactly WIDTH clock edges after the accept edge (32 for the default).
  - Throughput is one product per WIDTH+2 cycles minimum.
- a, b and start_valid are sampled only on the accept edge. Changes during RUN/DONE are ignored, and start_valid in RUN/DONE is not acknowledged.
- Backpressure: product and result_valid hold indefinitely while result_ready=0.
- No new accept in the same cycle as result handoff; IDLE is always visited for at least one cycle.
- rst_n asserted mid-RUN or mid-DONE aborts immediately. The partial product is discarded and product reads 0.
- Boundaries:
  - b=0 or a=0 gives product 0 after the full WIDTH cycles (no early exit).
  - All-ones operands must not overflow the 2*WIDTH result.

Optional Feature:
SIGNED_MULT_EN
- Defined: operands are two's-complement.
  - On accept, negative a/b are stored as magnitudes; neg_flag<=a[MSB]^b[MSB].
  - On the final RUN iteration, the product is two's-complement negated before registering when neg_flag=1.
  - Latency is unchanged.
  - The most-negative operand (0x80000000) magnitude is treated as unsigned 2^31. This is correct because the product fits 2*WIDTH bits.
- Undefined: purely unsigned, no neg_flag register.

Decomposition:
- Shared package mult_pkg:
  - State encoding constants ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2.
  - Default WIDTH.
  - Count width = clog2(WIDTH).
- One sub-module: add_stage. A combinational WIDTH-bit adder with carry-in and carry-out, instantiated once for the partial-sum add. This keeps the adder swappable with other adder architectures in the codebase.

Test Plan:
- a=3, b=5, accept at cycle 0 -> result_valid high after exactly 32 edges, product=0x000000000000000F. busy high for 32 cycles.
- a=0xFFFFFFFF, b=0xFFFFFFFF -> product=0xFFFFFFFE00000001. Carry path is exercised with no truncation.
- a=7, b=9, result_ready held 0 for 5 cycles after result_valid -> product=0x3F stable and result_valid held; start_valid pulses meanwhile are not accepted (start_ready=0).
- Accept a=0x1234, b=0x10. Pulse rst_n low at RUN count 10 -> outputs go to 0 asynchronously and state is IDLE. A fresh a=2, b=2 then yields 4.
- a=0xFFFFFFFD, b=5:
  - Without SIGNED_MULT_EN -> 0x00000004FFFFFFF1.
  - With SIGNED_MULT_EN -> 0xFFFFFFFFFFFFFFF1 (-15).
- With SIGNED_MULT_EN, a=0x80000000, b=0xFFFFFFFF -> 0x0000000080000000.
